// File: rtl/peripheral_msi_arbiter_wb_pkg.sv
// Shared types and sizing helpers for the MSI Wishbone arbiter family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package peripheral_msi_arbiter_wb_pkg;

    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_width(input int nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

    // Width of the watchdog counter; a disabled watchdog still gets one bit.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/peripheral_msi_rr_arbiter_wb.sv
// Round-robin picker: first requester after 'last' (wrapping modulo NM) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register gnt.
// Ports: req (one bit per master), last (previous winner) in;
//        gnt (winning index), valid (any requester) out.
module peripheral_msi_rr_arbiter_wb
    import peripheral_msi_arbiter_wb_pkg::*;
#(
    parameter int NM = 4,
    localparam int IW = idx_width(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt,
    output logic          valid
);

    // Scan offsets 1..NM so that 'last' itself is considered only after
    // every other master; the first hit locks the result.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int off = 1; off <= NM; off++) begin
            if (!valid && req[(int'(last) + off) % NM]) begin
                valid = 1'b1;
                gnt   = IW'((int'(last) + off) % NM);
            end
        end
    end

endmodule

// File: rtl/peripheral_msi_arbiter_wb.sv
// Round-robin Wishbone arbiter sharing one slave port among NM masters, with a strobe-to-ack watchdog.
// Latency: grant one cycle after cyc is seen in IDLE; request mux and ack return are combinational.
// Backpressure: grant held for the whole cyc; a slave silent for TIMEOUT cycles gets the cycle aborted with err.
// Ports: wb_clk/wb_rst (sync, active-high); wbm_* packed per-master slices in, wbm_dat_o/ack/err out;
//        wbs_* single slave port; grant_o registered one-hot owner (zero in IDLE).
module peripheral_msi_arbiter_wb
    import peripheral_msi_arbiter_wb_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic [NM*AW-1:0]    wbm_adr_i,
    input  logic [NM*DAT_W-1:0] wbm_dat_i,
    input  logic [NM*SEL_W-1:0] wbm_sel_i,
    input  logic [NM-1:0]       wbm_we_i,
    input  logic [NM-1:0]       wbm_cyc_i,
    input  logic [NM-1:0]       wbm_stb_i,
    output logic [DAT_W-1:0]    wbm_dat_o,
    output logic [NM-1:0]       wbm_ack_o,
    output logic [NM-1:0]       wbm_err_o,
    output logic [AW-1:0]       wbs_adr_o,
    output logic [DAT_W-1:0]    wbs_dat_o,
    output logic [SEL_W-1:0]    wbs_sel_o,
    output logic                wbs_we_o,
    output logic                wbs_cyc_o,
    output logic                wbs_stb_o,
    input  logic [DAT_W-1:0]    wbs_dat_i,
    input  logic                wbs_ack_i,
    output logic [NM-1:0]       grant_o
);

    localparam int IW = idx_width(NM);
    localparam int WW = wd_width(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [NM-1:0] grant_q, grant_d;

    logic [IW-1:0] pick_idx;
    logic          pick_vld;

    // Per-master views of the packed request buses.
    logic [AW-1:0]    m_adr [NM];
    logic [DAT_W-1:0] m_dat [NM];
    logic [SEL_W-1:0] m_sel [NM];

    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign m_adr[i] = wbm_adr_i[i*AW +: AW];
        assign m_dat[i] = wbm_dat_i[i*DAT_W +: DAT_W];
        assign m_sel[i] = wbm_sel_i[i*SEL_W +: SEL_W];
    end

    peripheral_msi_rr_arbiter_wb #(
        .NM (NM)
    ) u_rr (
        .req   (wbm_cyc_i),
        .last  (last_q),
        .gnt   (pick_idx),
        .valid (pick_vld)
    );

    logic g_cyc, g_stb;
    logic wd_run, wd_expire;

    assign g_cyc = wbm_cyc_i[g_q];
    assign g_stb = wbm_stb_i[g_q];

    // The watchdog only runs while the owner is strobing and the slave is
    // silent; any ack, idle strobe or state change clears it.
    assign wd_run    = (state_q == BUSY) && g_stb && !wbs_ack_i;
    // Expiry needs the owner still in its cycle: a cyc drop in the same
    // cycle wins and returns to IDLE without an error.
    assign wd_expire = (TIMEOUT != 0) && wd_run && g_cyc
                       && (wd_q == WW'(TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (wd_run) begin
            wd_d = (wd_q == {WW{1'b1}}) ? wd_q : wd_q + WW'(1);
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_q;

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        grant_d   = grant_q;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbm_ack_o = '0;
        wbm_err_o = '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_vld) begin
                    state_d           = BUSY;
                    g_d               = pick_idx;
                    last_d            = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                end
            end

            BUSY: begin
                wbs_cyc_o      = g_cyc;
                wbs_stb_o      = g_stb;
                wbs_adr_o      = m_adr[g_q];
                wbs_dat_o      = m_dat[g_q];
                wbs_sel_o      = m_sel[g_q];
                wbs_we_o       = wbm_we_i[g_q];
                wbm_ack_o[g_q] = wbs_ack_i;
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (wd_expire) begin
                    state_d = ABORT;
                end
            end

            ABORT: begin
                wbm_err_o[g_q] = 1'b1;
                state_d        = IDLE;
                grant_d        = '0;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_peripheral_msi_arbiter_wb.sv
`timescale 1ns/1ps
module tb_peripheral_msi_arbiter_wb;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int TO = 8;

    logic                wb_clk = 1'b0;
    logic                wb_rst;
    logic [NM*AW-1:0]    wbm_adr_i;
    logic [NM*32-1:0]    wbm_dat_i;
    logic [NM*4-1:0]     wbm_sel_i;
    logic [NM-1:0]       wbm_we_i;
    logic [NM-1:0]       wbm_cyc_i;
    logic [NM-1:0]       wbm_stb_i;
    logic [31:0]         wbm_dat_o;
    logic [NM-1:0]       wbm_ack_o;
    logic [NM-1:0]       wbm_err_o;
    logic [AW-1:0]       wbs_adr_o;
    logic [31:0]         wbs_dat_o;
    logic [3:0]          wbs_sel_o;
    logic                wbs_we_o;
    logic                wbs_cyc_o;
    logic                wbs_stb_o;
    logic [31:0]         wbs_dat_i;
    logic                wbs_ack_i;
    logic [NM-1:0]       grant_o;

    peripheral_msi_arbiter_wb #(.NM(NM), .AW(AW), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct packed {
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [NM-1:0] gnt;
        logic          cyc;
        logic [AW-1:0] adr;
        logic [31:0]   wdat;
        logic          we;
        logic [31:0]   rdat;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_ev, exp_ev;
    int  tests = 0;
    int  fails = 0;

    logic [AW-1:0] m_adr [NM];
    logic [31:0]   m_dat [NM];
    logic          m_we  [NM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [AW-1:0] a, input logic w, input logic [31:0] d);
        m_adr[m] = a;
        m_dat[m] = d;
        m_we[m]  = w;
        wbm_adr_i[m*AW +: AW] = a;
        wbm_dat_i[m*32 +: 32] = d;
        wbm_we_i[m]           = w;
        wbm_sel_i[m*4 +: 4]   = 4'hF;
        wbm_cyc_i[m]          = 1'b1;
        wbm_stb_i[m]          = 1'b1;
    endtask

    task automatic drop_m(input int m);
        wbm_cyc_i[m] = 1'b0;
        wbm_stb_i[m] = 1'b0;
    endtask

    // Wait (bounded) for master m to own a strobing slave port, ack it for one
    // cycle, then lower its strobe (and cyc when drop is set).
    task automatic xfer(input int m, input int exp_wait, input logic drop, input string name);
        int   n;
        ev_t  e;
        logic [31:0] rd;
        n = 0;
        while (!(grant_o[m] && wbs_stb_o) && n < 40) begin
            tick();
            n++;
        end
        check({name, "_wait"}, n, exp_wait);
        if (n < 40) begin
            rd        = 32'hD000_0000 | (m_adr[m] & 32'hFFFF);
            wbs_dat_i = rd;
            wbs_ack_i = 1'b1;
            e         = '0;
            e.ack[m]  = 1'b1;
            e.gnt[m]  = 1'b1;
            e.cyc     = 1'b1;
            e.adr     = m_adr[m];
            e.wdat    = m_dat[m];
            e.we      = m_we[m];
            e.rdat    = rd;
            exp_q.push_back(e);
            tick();
            wbs_ack_i    = 1'b0;
            wbm_stb_i[m] = 1'b0;
            if (drop) wbm_cyc_i[m] = 1'b0;
        end
    endtask

    // Monitor: any ack or err on the master side must match the next expected event.
    always @(negedge wb_clk) begin
        if (!wb_rst && ((|wbm_ack_o) || (|wbm_err_o))) begin
            act_ev.ack  = wbm_ack_o;
            act_ev.err  = wbm_err_o;
            act_ev.gnt  = grant_o;
            act_ev.cyc  = wbs_cyc_o;
            act_ev.adr  = wbs_adr_o;
            act_ev.wdat = wbs_dat_o;
            act_ev.we   = wbs_we_o;
            act_ev.rdat = wbm_dat_o;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: ack=%b err=%b gnt=%b adr=0x%0h, none expected",
                         act_ev.ack, act_ev.err, act_ev.gnt, act_ev.adr);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    fails++;
                    $display("FAIL event: got ack=%b err=%b gnt=%b cyc=%b adr=0x%0h wd=0x%0h we=%b rd=0x%0h; expected ack=%b err=%b gnt=%b cyc=%b adr=0x%0h wd=0x%0h we=%b rd=0x%0h",
                             act_ev.ack, act_ev.err, act_ev.gnt, act_ev.cyc, act_ev.adr, act_ev.wdat, act_ev.we, act_ev.rdat,
                             exp_ev.ack, exp_ev.err, exp_ev.gnt, exp_ev.cyc, exp_ev.adr, exp_ev.wdat, exp_ev.we, exp_ev.rdat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        ev_t  e;
        wb_rst    = 1'b1;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        wbm_we_i  = '0;
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        wbs_dat_i = '0;
        wbs_ack_i = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
            m_we[i]  = 1'b0;
        end
        repeat (3) tick();

        // Reset state
        check("rst_grant", grant_o, 0);
        check("rst_wbs_cyc", wbs_cyc_o, 0);
        check("rst_wbs_stb", wbs_stb_o, 0);
        check("rst_wbs_adr", wbs_adr_o, 0);
        check("rst_ack", wbm_ack_o, 0);
        check("rst_err", wbm_err_o, 0);

        // Masters 0 and 2 contend straight out of reset: 0 first, then 2.
        wb_rst = 1'b0;
        set_m(0, 32'h100, 1'b1, 32'hA000_0000);
        set_m(2, 32'h300, 1'b0, 32'hA000_0002);
        xfer(0, 1, 1'b1, "t1_m0");
        check("t1_still_busy", grant_o, 4'b0001);
        tick();
        check("t1_dead", grant_o, 0);
        xfer(2, 1, 1'b1, "t1_m2");
        tick();
        check("t1_dead2", grant_o, 0);

        // Fresh priority, then all four request continuously.
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        for (int m = 0; m < NM; m++) set_m(m, 32'h1000 + 32'(m) * 32'h100, m[0], 32'hB000_0000 + 32'(m));
        for (int k = 0; k < 5; k++) begin
            xfer(k % NM, 1, 1'b1, "t2_rr");
            if (k == 4) wbm_cyc_i = '0;
            if (k == 4) wbm_stb_i = '0;
            tick();
            check("t2_dead", grant_o, 0);
            if (k < 4) set_m(k % NM, 32'h1000 + 32'(k % NM) * 32'h100 + 32'h10 + 32'(k), 1'b1, 32'hC000_0000 + 32'(k));
        end

        // Master 1 does three strobes in one cycle while master 3 waits.
        set_m(1, 32'h2000, 1'b1, 32'h2000_0001);
        set_m(3, 32'h3000, 1'b0, 32'h3000_0003);
        xfer(1, 1, 1'b0, "t3_s1");
        set_m(1, 32'h2004, 1'b0, 32'h2000_0002);
        xfer(1, 0, 1'b0, "t3_s2");
        set_m(1, 32'h2008, 1'b1, 32'h2000_0003);
        xfer(1, 0, 1'b1, "t3_s3");
        tick();
        check("t3_dead", grant_o, 0);
        xfer(3, 1, 1'b1, "t3_m3");
        tick();

        // Watchdog: slave never acks master 2.
        wbs_dat_i = 32'hEEEE_0000;
        set_m(2, 32'h4000, 1'b0, 32'h4000_0000);
        n = 0;
        while (!(grant_o[2] && wbs_stb_o) && n < 40) begin tick(); n++; end
        check("t4_grant_wait", n, 1);
        e        = '0;
        e.err[2] = 1'b1;
        e.gnt[2] = 1'b1;
        e.rdat   = 32'hEEEE_0000;
        exp_q.push_back(e);
        n = 0;
        while (wbm_err_o == '0 && n < 30) begin tick(); n++; end
        check("t4_abort_cycle", n, TO);
        check("t4_err", wbm_err_o, 4'b0100);
        check("t4_wbs_cyc", wbs_cyc_o, 0);
        check("t4_ack", wbm_ack_o, 0);
        drop_m(2);
        tick();
        check("t4_idle_err", wbm_err_o, 0);
        check("t4_idle_grant", grant_o, 0);

        // Ack lands in the expiry cycle: delivered, no abort.
        set_m(1, 32'h5000, 1'b1, 32'h5000_0001);
        n = 0;
        while (!(grant_o[1] && wbs_stb_o) && n < 40) begin tick(); n++; end
        check("t5_grant_wait", n, 1);
        repeat (TO - 1) tick();
        check("t5_no_early_err", wbm_err_o, 0);
        wbs_dat_i = 32'h5555_AAAA;
        wbs_ack_i = 1'b1;
        e         = '0;
        e.ack[1]  = 1'b1;
        e.gnt[1]  = 1'b1;
        e.cyc     = 1'b1;
        e.adr     = 32'h5000;
        e.wdat    = 32'h5000_0001;
        e.we      = 1'b1;
        e.rdat    = 32'h5555_AAAA;
        exp_q.push_back(e);
        tick();
        wbs_ack_i = 1'b0;
        check("t5_still_busy", grant_o, 4'b0010);
        check("t5_no_err", wbm_err_o, 0);
        drop_m(1);
        tick();
        check("t5_idle_err", wbm_err_o, 0);
        check("t5_idle_grant", grant_o, 0);

        // Reset mid-transfer: master 0 must then beat master 3.
        set_m(1, 32'h6000, 1'b0, 32'h6000_0001);
        n = 0;
        while (!(grant_o[1] && wbs_stb_o) && n < 40) begin tick(); n++; end
        check("t6_grant_wait", n, 1);
        wb_rst = 1'b1;
        set_m(0, 32'h7000, 1'b1, 32'h7000_0000);
        set_m(3, 32'h7300, 1'b1, 32'h7000_0003);
        tick();
        wb_rst = 1'b0;
        check("t6_grant", grant_o, 0);
        check("t6_wbs_cyc", wbs_cyc_o, 0);
        check("t6_wbs_stb", wbs_stb_o, 0);
        check("t6_wbs_adr", wbs_adr_o, 0);
        check("t6_wbs_dat", wbs_dat_o, 0);
        check("t6_wbs_sel", wbs_sel_o, 0);
        check("t6_wbs_we", wbs_we_o, 0);
        drop_m(1);
        xfer(0, 1, 1'b1, "t6_m0");
        drop_m(3);
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/peripheral_msi_arbiter_wb.md
# peripheral_msi_arbiter_wb

Round-robin Wishbone arbiter that shares one slave port between NM single-clock masters. Typical placement is in front of a clock-domain-crossing bridge or a shared peripheral. It grants one master at a time and holds the grant for the whole `cyc` cycle. It multiplexes that master's request onto the slave port and routes `ack` back to it. A bus-watchdog terminates stalled transfers with `err`, so one hung slave cannot lock out all masters.

## Interface
Parameters:
- `NM`, 4: number of masters, 2..16.
- `AW`, 32: address width.
- `TIMEOUT`, 255: cycles allowed from slave strobe to `ack` before abort; 0 disables the watchdog.

Ports:
- `wb_clk` in 1: single clock; all state on rising edge.
- `wb_rst` in 1: reset, synchronous, active-high.
- `wbm_adr_i` in NM*AW: master addresses; master i occupies slice [i*AW +: AW].
- `wbm_dat_i` in NM*32: master write data.
- `wbm_sel_i` in NM*4: master byte selects.
- `wbm_we_i` in NM: master write enables.
- `wbm_cyc_i` in NM: master cycle requests.
- `wbm_stb_i` in NM: master strobes.
- `wbm_dat_o` out 32: slave read data, broadcast to all masters.
- `wbm_ack_o` out NM: per-master acknowledge.
- `wbm_err_o` out NM: per-master watchdog error.
- `wbs_adr_o` out AW: slave address.
- `wbs_dat_o` out 32: slave write data.
- `wbs_sel_o` out 4: slave byte selects.
- `wbs_we_o` out 1: slave write enable.
- `wbs_cyc_o` out 1: slave cycle.
- `wbs_stb_o` out 1: slave strobe.
- `wbs_dat_i` in 32: slave read data.
- `wbs_ack_i` in 1: slave acknowledge.
- `grant_o` out NM: one-hot current grant, for debug and monitoring.

## Operation
- State machine with three states: IDLE, BUSY, ABORT.
- IDLE:
  - If any `wbm_cyc_i` is high, the round-robin pick is registered as the grant index `g` and the state moves to BUSY.
  - Otherwise the state stays IDLE.
- Round-robin rule:
  - Search order is `last+1`, `last+2`, … wrapping modulo NM; the first requester in that order wins.
  - `last` is updated to `g` on every grant.
  - Reset value of `last` is NM-1, so master 0 has first priority.
- BUSY:
  - `wbs_cyc_o = wbm_cyc_i[g]`, `wbs_stb_o = wbm_stb_i[g]`.
  - `wbs_adr_o`, `wbs_dat_o`, `wbs_sel_o` and `wbs_we_o` come from master `g`'s slices.
  - `wbm_ack_o[g] = wbs_ack_i`; all other `wbm_ack_o` bits are 0.
  - When `wbm_cyc_i[g]` is low, the state returns to IDLE. Multiple strobes within one `cyc` stay with `g`.
- Watchdog:
  - Counter `wd` clears whenever it is not the case that state is BUSY, `wbm_stb_i[g]` is high and `wbs_ack_i` is low; otherwise it increments.
  - When `wd == TIMEOUT-1` and `wbs_ack_i` is low, the state goes to ABORT.
  - Counter width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.
- ABORT, one cycle:
  - `wbm_err_o[g] = 1`, `wbm_ack_o = 0`, `wbs_cyc_o = wbs_stb_o = 0`; next state is IDLE.
  - If the master keeps `cyc` high, it re-enters arbitration as a normal requester.
- Outside BUSY:
  - All `wbs_*` outputs are 0 and all `wbm_ack_o` bits are 0.
  - `wbm_dat_o = wbs_dat_i` always.
- Simultaneous events:
  - `wbs_ack_i` in the same cycle the watchdog expires: the ack wins, with no abort.
  - Granted `cyc` dropping in the same cycle as expiry: go to IDLE, with no err.
- Reset while BUSY or ABORT: next cycle is IDLE; all outputs are 0 and `last` is NM-1.

## Timing
- Reset values:
  - `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o`, `wbs_adr_o`, `wbs_dat_o`, `wbs_sel_o` = 0.
  - `wbm_ack_o`, `wbm_err_o`, `grant_o` = 0.
- Grant latency: with `cyc` sampled high at edge k in IDLE, `wbs_cyc_o` is high during cycle k+1.
- Turnaround: a master's `cyc` falling at edge k gives IDLE in cycle k+1; the next grant drives the slave in cycle k+2. This is one dead cycle between owners.
- Ack path is combinational (slave to master, zero cycles). The request mux is combinational from registered `g`.
- Watchdog: with the strobe first driven in cycle c and no ack, ABORT occurs in cycle c+TIMEOUT; `err` is high for exactly one cycle.
- `grant_o` is registered and one-hot in BUSY and ABORT, zero in IDLE.

## Structure
- Package `peripheral_msi_arbiter_wb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, BUSY, ABORT);
  - localparam helpers for index width `$clog2(NM)` and watchdog width.
- Sub-module `peripheral_msi_rr_arbiter_wb` is a purely combinational picker: `req[NM]` and `last` in, `gnt` index and `valid` out. It is reused by other MSI interconnect blocks.

## Test plan
- After reset, masters 0 and 2 both raise `cyc`/`stb` → `grant_o=4'b0001` in cycle 1; slave sees master 0 `adr=0x100`; `wbm_ack_o=4'b0001` on slave ack.
- All four masters request continuously, each dropping `cyc` after one ack → grant order 0,1,2,3,0; one idle cycle between grants.
- Master 1 issues 3 strobes in one `cyc` while master 3 requests → three acks to master 1; master 3 is granted only after master 1's `cyc` drops.
- `TIMEOUT=8`, slave never acks → `wbm_err_o[g]=1` exactly 8 cycles after the strobe, `wbs_cyc_o=0` that cycle, then IDLE.
- Slave ack arrives in the watchdog-expiry cycle → `ack` delivered, no `err`, state stays BUSY.
- `wb_rst` pulsed mid-transfer → next cycle all outputs 0; master 0 wins the next contention against master 3.
